armleocpu_simple2axi_converter: RTL



---
 rtl/armleocpu_simple2axi_converter_pkg.sv | 39 +++
 rtl/armleocpu_simple2axi_converter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_simple2axi_converter_pkg.sv
// Shared AXI encodings and FSM state type for the simple<->AXI converters.
package armleocpu_simple2axi_converter_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_8 = 3'd3;

    typedef enum logic [2:0] {
        StIdle,
        StWriteReq,
        StWriteResp,
        StReadAddr,
        StReadData
    } state_t;

    typedef struct packed {
        logic address_error;
        logic access_error;
    } err_t;

    // DECERR wins so the two flags never assert together.
    function automatic err_t resp_to_err(input logic [1:0] resp, input logic last);
        err_t e;
        e.address_error = (resp == AXI_RESP_DECERR);
        e.access_error  = !e.address_error && ((resp == AXI_RESP_SLVERR) || !last);
        return e;
    endfunction

endpackage

// File: rtl/armleocpu_simple2axi_converter.sv
// Simple single-word request to single-beat AXI4 initiator bridge.
// Define ARMLEOCPU_SIMPLE2AXI_ALIGN_CHECK_EN to reject misaligned addresses locally.
module armleocpu_simple2axi_converter
    import armleocpu_simple2axi_converter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 34,
    parameter int unsigned ID_WIDTH       = 4,
    parameter int unsigned TRANSACTION_ID = 0,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_byteenable,
    output logic                      done,
    output logic [DATA_WIDTH-1:0]     read_data,
    output logic                      address_error,
    output logic                      access_error,

    output logic                      axi_awvalid,
    input  logic                      axi_awready,
    output logic [ID_WIDTH-1:0]       axi_awid,
    output logic [ADDR_WIDTH-1:0]     axi_awaddr,
    output logic [7:0]                axi_awlen,
    output logic [2:0]                axi_awsize,
    output logic [1:0]                axi_awburst,

    output logic                      axi_wvalid,
    input  logic                      axi_wready,
    output logic [DATA_WIDTH-1:0]     axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   axi_wstrb,
    output logic                      axi_wlast,

    input  logic                      axi_bvalid,
    output logic                      axi_bready,
    input  logic [1:0]                axi_bresp,
    input  logic [ID_WIDTH-1:0]       axi_bid,

    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic [ID_WIDTH-1:0]       axi_arid,
    output logic [ADDR_WIDTH-1:0]     axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,

    input  logic                      axi_rvalid,
    output logic                      axi_rready,
    input  logic [1:0]                axi_rresp,
    input  logic                      axi_rlast,
    input  logic [DATA_WIDTH-1:0]     axi_rdata,
    input  logic [ID_WIDTH-1:0]       axi_rid
);

    state_t                    state_q, state_d;
    logic                      awvalid_q, awvalid_d;
    logic                      wvalid_q, wvalid_d;
    logic                      bready_q, bready_d;
    logic                      arvalid_q, arvalid_d;
    logic                      rready_q, rready_d;
    logic                      done_q, done_d;
    logic [DATA_WIDTH-1:0]     read_data_q, read_data_d;
    err_t                      err_q, err_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic                      misaligned;

    // Response IDs are never compared; a single ID is ever outstanding.
    logic unused_ids;
    assign unused_ids = ^{axi_bid, axi_rid};

`ifdef ARMLEOCPU_SIMPLE2AXI_ALIGN_CHECK_EN
    assign misaligned = (address[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            done_q      <= 1'b0;
            read_data_q <= '0;
            err_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            done_q      <= done_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        done_d      = 1'b0;
        read_data_d = read_data_q;
        err_d       = err_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        unique case (state_q)
            StIdle: begin
                // The request is still asserted while done is high; don't relaunch it.
                if (!done_q && (write || read)) begin
                    if (misaligned) begin
                        done_d              = 1'b1;
                        err_d.address_error = 1'b1;
                        err_d.access_error  = 1'b0;
                    end else if (write) begin
                        addr_d    = address;
                        wdata_d   = write_data;
                        wstrb_d   = write_byteenable;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWriteReq;
                    end else begin
                        addr_d    = address;
                        arvalid_d = 1'b1;
                        state_d   = StReadAddr;
                    end
                end
            end
            StWriteReq: begin
                if (axi_awready) awvalid_d = 1'b0;
                if (axi_wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = StWriteResp;
                end
            end
            StWriteResp: begin
                if (axi_bvalid) begin
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    err_d    = resp_to_err(axi_bresp, 1'b1);
                    state_d  = StIdle;
                end
            end
            StReadAddr: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StReadData;
                end
            end
            StReadData: begin
                if (axi_rvalid) begin
                    rready_d    = 1'b0;
                    done_d      = 1'b1;
                    read_data_d = axi_rdata;
                    err_d       = resp_to_err(axi_rresp, axi_rlast);
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign done          = done_q;
    assign read_data     = read_data_q;
    assign address_error = err_q.address_error;
    assign access_error  = err_q.access_error;

    assign axi_awvalid = awvalid_q;
    assign axi_awid    = ID_WIDTH'(TRANSACTION_ID);
    assign axi_awaddr  = addr_q;
    assign axi_awlen   = 8'd0;
    assign axi_awsize  = AXI_SIZE_4;
    assign axi_awburst = AXI_BURST_INCR;

    assign axi_wvalid = wvalid_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = wstrb_q;
    assign axi_wlast  = 1'b1;

    assign axi_bready = bready_q;

    assign axi_arvalid = arvalid_q;
    assign axi_arid    = ID_WIDTH'(TRANSACTION_ID);
    assign axi_araddr  = addr_q;
    assign axi_arlen   = 8'd0;
    assign axi_arsize  = AXI_SIZE_4;
    assign axi_arburst = AXI_BURST_INCR;

    assign axi_rready = rready_q;

endmodule
